// File: rtl/rr_slot_arbiter_pkg.sv
// Shared types and width helpers for the round-robin slot arbiter.
package rr_slot_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // Bits needed to index v items; never less than one bit.
    function automatic int unsigned clog2w(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_IDX_W = clog2w(DEF_N);

endpackage

// File: rtl/rr_slot_arbiter_hold_timer.sv
// Modulo-MAX_HOLD cycle counter bounding how long a single grant may last.
module hold_timer
    import rr_slot_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CW       = clog2w(MAX_HOLD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          term_c
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign term_c  = (count_q == CW'(MAX_HOLD - 1));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = term_c ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rr_slot_arbiter.sv
// Round-robin arbiter granting one requester at a time, released by done or by
// a MAX_HOLD timeout, with a one-cycle gap between consecutive grants.
module rr_slot_arbiter
    import rr_slot_arbiter_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned W        = DEF_IDX_W,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic         timeout
);

    localparam int unsigned HW = clog2w(MAX_HOLD);

    arb_state_e   state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic         gnt_valid_q, gnt_valid_d;
    logic [W-1:0] gnt_idx_q, gnt_idx_d;
    logic         timeout_q, timeout_d;

    logic [W-1:0] sel_idx;
    logic         sel_found;
    int unsigned  srch_j;

    logic [HW-1:0] hold_cnt;
    logic          hold_term;
    logic          hold_clr;
    logic          unused_hold;

    assign unused_hold = ^hold_cnt;

    // First set request at or above ptr, wrapping modulo N.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        srch_j    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            srch_j = 32'(ptr_q) + off;
            if (srch_j >= N) begin
                srch_j = srch_j - N;
            end
            if (!sel_found && req[W'(srch_j)]) begin
                sel_found = 1'b1;
                sel_idx   = W'(srch_j);
            end
        end
    end

    assign hold_clr = (state_q != GRANT) && (state_d == GRANT);

    hold_timer #(
        .MAX_HOLD (MAX_HOLD),
        .CW       (HW)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (hold_clr),
        .en_i    (state_q == GRANT),
        .count_o (hold_cnt),
        .term_c  (hold_term)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d     = GRANT;
                    gnt_d       = N'(1) << sel_idx;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = sel_idx;
                end
            end
            GRANT: begin
                // done wins over a coincident terminal count: no timeout then.
                if (done || hold_term) begin
                    state_d     = GAP;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_idx_d   = '0;
                    ptr_d       = (gnt_idx_q == W'(N - 1)) ? '0 : gnt_idx_q + W'(1);
                    timeout_d   = !done;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Directed scoreboard bench for rr_slot_arbiter (N=4, MAX_HOLD=8).
module tb_rr_slot_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] idx;
        logic       to;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    obs_t sb[$];

    rr_slot_arbiter #(.N(4), .W(2), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk_exp(input logic [3:0] g, input logic t);
        obs_t e;
        e.gnt   = g;
        e.valid = (g != 4'b0000);
        e.idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) e.idx = 2'(i);
        end
        e.to = t;
        return e;
    endfunction

    task automatic compare(input string tag);
        obs_t got;
        obs_t e;
        got = '{gnt: gnt, valid: gnt_valid, idx: gnt_idx, to: timeout};
        e   = sb.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s: observed gnt=%b valid=%b idx=%0d to=%b expected gnt=%b valid=%b idx=%0d to=%b",
                   tag, got.gnt, got.valid, got.idx, got.to, e.gnt, e.valid, e.idx, e.to);
        end
    endtask

    // Drive one cycle of inputs and check outputs after the following edge.
    task automatic cyc(input string tag, input logic [3:0] r, input logic d,
                       input logic [3:0] eg, input logic et);
        @(negedge clk);
        req  = r;
        done = d;
        sb.push_back(mk_exp(eg, et));
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    // Every sampled cycle: grant is one-hot-or-zero and valid tracks it.
    always @(negedge clk) begin
        checks++;
        assert ($onehot0(gnt) && (gnt_valid === (|gnt))) else begin
            errors++;
            $error("FAIL onehot: observed gnt=%b valid=%b expected one-hot-or-zero with valid=|gnt",
                   gnt, gnt_valid);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk_exp(4'b0000, 1'b0));
        compare("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // All requesting, done on the 3rd grant cycle: rotation 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            cyc("rot_grant", 4'b1111, 1'b0, 4'b0001 << (k % 4), 1'b0);
            cyc("rot_hold2", 4'b1111, 1'b0, 4'b0001 << (k % 4), 1'b0);
            cyc("rot_hold3", 4'b1111, 1'b0, 4'b0001 << (k % 4), 1'b0);
            cyc("rot_rel",   4'b1111, 1'b1, 4'b0000, 1'b0);
            cyc("rot_gap",   4'b1111, 1'b0, 4'b0000, 1'b0);
        end
        // ptr is now 1.

        // Single requester, no done: exactly 8 grant cycles then timeout.
        cyc("to_grant", 4'b0100, 1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < 7; i++) cyc("to_hold", 4'b0100, 1'b0, 4'b0100, 1'b0);
        cyc("to_pulse", 4'b0100, 1'b0, 4'b0000, 1'b1);
        cyc("to_clear", 4'b0000, 1'b0, 4'b0000, 1'b0);
        // ptr is now 3.

        // Wrap-around search from ptr=3 picks index 0.
        cyc("wrap_grant", 4'b0011, 1'b0, 4'b0001, 1'b0);
        cyc("wrap_rel",   4'b0011, 1'b1, 4'b0000, 1'b0);
        cyc("wrap_gap",   4'b0000, 1'b0, 4'b0000, 1'b0);
        // ptr is now 1.

        // done on the terminal count, req dropped mid-grant: release, no timeout.
        cyc("term_grant", 4'b0010, 1'b0, 4'b0010, 1'b0);
        for (int i = 0; i < 7; i++) cyc("term_hold_noreq", 4'b0000, 1'b0, 4'b0010, 1'b0);
        cyc("term_done", 4'b0000, 1'b1, 4'b0000, 1'b0);
        cyc("term_gap",  4'b0000, 1'b0, 4'b0000, 1'b0);
        // ptr is now 2.

        // Reset in the 4th grant cycle drops the grant at once.
        cyc("rst_grant", 4'b1111, 1'b0, 4'b0100, 1'b0);
        for (int i = 0; i < 3; i++) cyc("rst_hold", 4'b1111, 1'b0, 4'b0100, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #1;
        sb.push_back(mk_exp(4'b0000, 1'b0));
        compare("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rst_after", 4'b1010, 1'b0, 4'b0010, 1'b0);
        cyc("rst_rel",   4'b1010, 1'b1, 4'b0000, 1'b0);
        cyc("rst_gap",   4'b0000, 1'b0, 4'b0000, 1'b0);
        // ptr is now 2.

        // Long idle with stray done pulses, then a 1-cycle grant latency.
        for (int i = 0; i < 20; i++) cyc("idle", 4'b0000, 1'(i % 2), 4'b0000, 1'b0);
        cyc("late_grant", 4'b1000, 1'b0, 4'b1000, 1'b0);
        cyc("late_rel",   4'b1000, 1'b1, 4'b0000, 1'b0);
        cyc("late_gap",   4'b1000, 1'b0, 4'b0000, 1'b0);
        // ptr wrapped from 3 to 0.
        cyc("ptr_wrap",   4'b1001, 1'b0, 4'b0001, 1'b0);
        cyc("ptr_rel",    4'b0000, 1'b1, 4'b0000, 1'b0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
